dm_mem_arb: RTL and testbench
=============================

Name: dm_mem_arb

Overview:
- Round-robin arbiter that shares the single debug-memory slave port (req/we/addr/be/wdata/rdata, one-cycle read latency) among NrPorts bus requesters, e.g. per-hart instruction fetch and load/store ports.
- Sits between the requesters and dm_mem inside the debug module top level.
- Issues at most one memory access per cycle and routes the response back to the granted port one cycle later.
- Blocks new grants while the debug module is inactive.

Parameters:
- NrPorts, 2, number of requester ports (>=1).
- AddrWidth, 32, address width.
- DataWidth, 32, data width; byte-enable width is DataWidth/8.

Ports:
- clk_i, input, 1, clock.
- rst_i, input, 1, asynchronous active-high reset.
- dmactive_i, input, 1, debug module active; low blocks new grants.
- req_i, input, NrPorts, per-port request.
- we_i, input, NrPorts, per-port write enable.
- addr_i, input, NrPorts*AddrWidth, per-port address, packed with port 0 at the LSBs.
- be_i, input, NrPorts*DataWidth/8, per-port byte enables.
- wdata_i, input, NrPorts*DataWidth, per-port write data.
- gnt_o, output, NrPorts, one-hot grant, combinational in the request cycle.
- rvalid_o, output, NrPorts, one-hot response valid, one cycle after grant.
- rdata_o, output, DataWidth, read data broadcast to all ports; qualified by rvalid_o.
- mem_req_o, output, 1, memory request.
- mem_we_o, output, 1, memory write enable.
- mem_addr_o, output, AddrWidth, memory address.
- mem_be_o, output, DataWidth/8, memory byte enables.
- mem_wdata_o, output, DataWidth, memory write data.
- mem_rdata_i, input, DataWidth, memory read data, valid the cycle after mem_req_o.

Behaviour:
- State:
  - rr_q: priority pointer, clog2(NrPorts) bits; 1 bit when NrPorts=1.
  - resp_q: one-hot, NrPorts bits.
- Reset (async, rst_i=1): rr_q=0, resp_q=0. gnt_o, rvalid_o and mem_req_o are all 0 during reset.
- Arbitration (combinational):
  - If dmactive_i=1, search ports starting at rr_q and going upward modulo NrPorts.
  - The first port with req_i=1 gets gnt_o=1; all other gnt_o bits are 0.
  - If dmactive_i=0 or no request is present, gnt_o=0.
- Memory drive:
  - mem_req_o = |gnt_o.
  - mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o are muxed from the granted port.
  - With no grant, all memory outputs are driven 0.
- Pointer update at the clock edge:
  - Grant to port k: rr_q <= (k+1) mod NrPorts.
  - No grant: rr_q holds.
  - Wrap: a grant to port NrPorts-1 sets rr_q to 0.
- Response:
  - resp_q <= gnt_o every cycle; rvalid_o = resp_q.
  - rdata_o = mem_rdata_i, passed combinationally.
  - Writes also return rvalid_o as an acknowledge; rdata_o is don't-care for writes.
- Requester protocol:
  - Hold req_i and the associated fields stable until gnt_o.
  - A requester may re-request in the cycle it receives rvalid_o.
  - Back-to-back grants to different ports are allowed every cycle (full throughput).
- Same-port repeat: a port that keeps requesting is granted again only after all other requesting ports have been served.
- dmactive_i dropping:
  - A response already in flight (resp_q≠0) is still delivered the next cycle.
  - No new grant is issued from that cycle onward.
- Reset asserted mid-transfer: the in-flight response is dropped (rvalid_o=0) and rr_q returns to 0.
- NrPorts=1: the arbiter degenerates to a pass-through gated by dmactive_i; rr_q stays 0.

Optional Feature:
- Macro: DM_MEM_ARB_STATS_EN.
- When defined:
  - Adds output grant_cnt_o, NrPorts*16 bits: one 16-bit counter per port, packed with port 0 at the LSBs.
  - Each counter increments on its port's grant and saturates at 16'hFFFF.
  - Counters reset to 0 on rst_i.
  - Counters clear synchronously while dmactive_i=0.
- When undefined: the port and counters are absent; arbitration behaviour is identical.

Test Plan:
- Single read: reset; dmactive_i=1; port0 reads addr 0x100 and the memory model returns 0xDEADBEEF -> gnt_o=01 in the request cycle; next cycle rvalid_o=01 with rdata_o=0xDEADBEEF; afterwards rr_q=1.
- Contention: NrPorts=2, both ports request continuously for 4 cycles starting from rr_q=0 -> grant sequence 01,10,01,10; rvalid_o follows one cycle later in the same order.
- Wrap-around: NrPorts=3, ports 0 and 2 request with rr_q=2 -> port2 granted first, then port0; rr_q ends at 1.
- Inactive: dmactive_i=0 with req_i=11 -> gnt_o=00 and mem_req_o=0. dmactive_i falls in the cycle after a grant -> the pending rvalid is still delivered.
- Write then reset: port1 writes 0x5A5A5A5A with be=4'b0011 -> mem_we_o=1 and mem_be_o=0011. Assert rst_i in the following cycle -> rvalid_o=00 immediately and rr_q=0.
- Stats (with DM_MEM_ARB_STATS_EN): port0 granted 70000 times -> grant_cnt_o[15:0] saturates at 0xFFFF; deasserting dmactive_i clears it to 0.

Source files
------------

// File: rtl/dm_mem_arb.sv
// Round-robin arbiter sharing the single debug-memory port among NrPorts requesters.
// Optional per-port grant counters are enabled with `define DM_MEM_ARB_STATS_EN.
module dm_mem_arb #(
   parameter int unsigned NrPorts   = 2,
   parameter int unsigned AddrWidth = 32,
   parameter int unsigned DataWidth = 32
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             dmactive_i,
   input  logic [NrPorts-1:0]               req_i,
   input  logic [NrPorts-1:0]               we_i,
   input  logic [NrPorts*AddrWidth-1:0]     addr_i,
   input  logic [NrPorts*(DataWidth/8)-1:0] be_i,
   input  logic [NrPorts*DataWidth-1:0]     wdata_i,
   output logic [NrPorts-1:0]               gnt_o,
   output logic [NrPorts-1:0]               rvalid_o,
   output logic [DataWidth-1:0]             rdata_o,
   output logic                             mem_req_o,
   output logic                             mem_we_o,
   output logic [AddrWidth-1:0]             mem_addr_o,
   output logic [DataWidth/8-1:0]           mem_be_o,
   output logic [DataWidth-1:0]             mem_wdata_o,
   input  logic [DataWidth-1:0]             mem_rdata_i
`ifdef DM_MEM_ARB_STATS_EN
   ,
   output logic [NrPorts*16-1:0]            grant_cnt_o
`endif
);

   localparam int unsigned BeWidth  = DataWidth / 8;
   localparam int unsigned PtrWidth = (NrPorts > 1) ? $clog2(NrPorts) : 1;

   // Handshake: a requester holds req_i and its fields stable until gnt_o (same
   // cycle); rvalid_o follows exactly one cycle after gnt_o and also acks writes.
   logic [PtrWidth-1:0] rr_q, rr_d;
   logic [NrPorts-1:0]  resp_q, gnt;
   logic                found;

   // Two passes: ports at or above the pointer first, then the wrapped ones.
   always_comb begin
      gnt   = '0;
      found = 1'b0;
      rr_d  = rr_q;
      for (int unsigned k = 0; k < NrPorts; k++) begin
         if (!found && req_i[k] && (k >= 32'(rr_q))) begin
            found  = 1'b1;
            gnt[k] = 1'b1;
            rr_d   = PtrWidth'((k + 1) % NrPorts);
         end
      end
      for (int unsigned k = 0; k < NrPorts; k++) begin
         if (!found && req_i[k]) begin
            found  = 1'b1;
            gnt[k] = 1'b1;
            rr_d   = PtrWidth'((k + 1) % NrPorts);
         end
      end
      if (!dmactive_i || rst_i) begin
         gnt  = '0;
         rr_d = rr_q;
      end
   end

   always_comb begin
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_be_o    = '0;
      mem_wdata_o = '0;
      for (int unsigned k = 0; k < NrPorts; k++) begin
         if (gnt[k]) begin
            mem_we_o    = we_i[k];
            mem_addr_o  = addr_i[k*AddrWidth +: AddrWidth];
            mem_be_o    = be_i[k*BeWidth +: BeWidth];
            mem_wdata_o = wdata_i[k*DataWidth +: DataWidth];
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_q   <= '0;
         resp_q <= '0;
      end else begin
         rr_q   <= rr_d;
         resp_q <= gnt;
      end
   end

   assign gnt_o     = gnt;
   assign mem_req_o = |gnt;
   assign rvalid_o  = resp_q;
   assign rdata_o   = mem_rdata_i;

`ifdef DM_MEM_ARB_STATS_EN
   logic [NrPorts-1:0][15:0] cnt_q;

   // Saturating counters; an inactive debug module wipes the statistics.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         for (int unsigned k = 0; k < NrPorts; k++) begin
            if (!dmactive_i) begin
               cnt_q[k] <= '0;
            end else if (gnt[k] && (cnt_q[k] != 16'hFFFF)) begin
               cnt_q[k] <= cnt_q[k] + 16'd1;
            end
         end
      end
   end

   assign grant_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_dm_mem_arb.sv
// Self-checking bench for dm_mem_arb (3 ports): directed scenarios plus a
// randomized run against a distance-based round-robin model and a memory scoreboard.
`timescale 1ns/1ps
module tb_dm_mem_arb;

   localparam int N  = 3;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int BW = DW / 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            dmactive;
   logic [N-1:0]    req, we;
   logic [N*AW-1:0] addr;
   logic [N*BW-1:0] be;
   logic [N*DW-1:0] wdata;
   logic [N-1:0]    gnt, rvalid;
   logic [DW-1:0]   rdata;
   logic            mem_req, mem_we;
   logic [AW-1:0]   mem_addr;
   logic [BW-1:0]   mem_be;
   logic [DW-1:0]   mem_wdata;
   logic [DW-1:0]   mem_rdata = '0;
`ifdef DM_MEM_ARB_STATS_EN
   logic [N*16-1:0] grant_cnt;
`endif

   int checks = 0;
   int errors = 0;
   int m_ptr  = 0;
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] slave_mem [0:255];
   logic [DW-1:0] ref_mem   [0:255];
   logic          p_we    [N];
   logic [AW-1:0] p_addr  [N];
   logic [BW-1:0] p_be    [N];
   logic [DW-1:0] p_wdata [N];

   dm_mem_arb #(.NrPorts(N), .AddrWidth(AW), .DataWidth(DW)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .dmactive_i  (dmactive),
      .req_i       (req),
      .we_i        (we),
      .addr_i      (addr),
      .be_i        (be),
      .wdata_i     (wdata),
      .gnt_o       (gnt),
      .rvalid_o    (rvalid),
      .rdata_o     (rdata),
      .mem_req_o   (mem_req),
      .mem_we_o    (mem_we),
      .mem_addr_o  (mem_addr),
      .mem_be_o    (mem_be),
      .mem_wdata_o (mem_wdata),
      .mem_rdata_i (mem_rdata)
`ifdef DM_MEM_ARB_STATS_EN
      ,
      .grant_cnt_o (grant_cnt)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "timeout");
   end

   // memory slave with one-cycle read latency
   always @(posedge clk) begin
      if (mem_req) begin
         if (mem_we) begin
            for (int b = 0; b < BW; b++)
               if (mem_be[b]) slave_mem[mem_addr[9:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
         end else begin
            mem_rdata <= slave_mem[mem_addr[9:2]];
         end
      end
   end

   // reference model: the requester at the smallest forward distance from the pointer wins
   function automatic logic [N-1:0] model_grant(input logic [N-1:0] r, input logic act,
                                                input int ptr, output int gp);
      int best_dist;
      logic [N-1:0] g;
      g = '0;
      gp = -1;
      best_dist = N;
      if (act) begin
         for (int p = 0; p < N; p++) begin
            if (r[p] && ((p - ptr + N) % N) < best_dist) begin
               best_dist = (p - ptr + N) % N;
               gp = p;
            end
         end
      end
      if (gp >= 0) g[gp] = 1'b1;
      return g;
   endfunction

   function automatic void ref_write(input logic [AW-1:0] a, input logic [BW-1:0] b,
                                     input logic [DW-1:0] d);
      for (int i = 0; i < BW; i++)
         if (b[i]) ref_mem[a[9:2]][i*8 +: 8] = d[i*8 +: 8];
   endfunction

   // driver tasks
   task automatic pack_ports();
      for (int p = 0; p < N; p++) begin
         we[p]                = p_we[p];
         addr[p*AW +: AW]     = p_addr[p];
         be[p*BW +: BW]       = p_be[p];
         wdata[p*DW +: DW]    = p_wdata[p];
      end
   endtask

   task automatic set_port(input int p, input logic w, input logic [AW-1:0] a,
                           input logic [BW-1:0] b, input logic [DW-1:0] d);
      p_we[p] = w; p_addr[p] = a; p_be[p] = b; p_wdata[p] = d;
      pack_ports();
   endtask

   task automatic set_idle();
      req = '0;
      for (int p = 0; p < N; p++) set_port(p, 1'b0, '0, '0, '0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      set_idle();
      @(negedge clk);
      rst = 1'b0;
      dmactive = 1'b1;
      m_ptr = 0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      req = '1;
      dmactive = 1'b1;
      #1;
      checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL reset_gnt got %b exp 000", gnt); end
      checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL reset_rvalid got %b exp 000", rvalid); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
      checks++; if (dut.rr_q !== 2'd0) begin errors++; $display("FAIL reset_rr got %0d exp 0", dut.rr_q); end
      do_reset();
   endtask

   task automatic test_single_read();
      slave_mem[8'h40] = 32'hDEADBEEF;
      ref_mem[8'h40]   = 32'hDEADBEEF;
      set_port(0, 1'b0, 32'h100, 4'hF, 32'h0);
      req = 3'b001;
      #1;
      checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL single_gnt got %b exp 001", gnt); end
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h100)
         begin errors++; $display("FAIL single_mem got req=%b we=%b addr=%h exp 1 0 100", mem_req, mem_we, mem_addr); end
      @(negedge clk);
      req = '0;
      #1;
      checks++; if (rvalid !== 3'b001) begin errors++; $display("FAIL single_rvalid got %b exp 001", rvalid); end
      checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata got %h exp deadbeef", rdata); end
      checks++; if (dut.rr_q !== 2'd1) begin errors++; $display("FAIL single_rr got %0d exp 1", dut.rr_q); end
   endtask

   task automatic test_contention();
      logic [N-1:0] exp_seq [4];
      logic [N-1:0] prev;
      exp_seq = '{3'b001, 3'b010, 3'b001, 3'b010};
      prev = '0;
      do_reset();
      set_port(0, 1'b0, 32'h0, 4'hF, 32'h0);
      set_port(1, 1'b0, 32'h4, 4'hF, 32'h0);
      req = 3'b011;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (gnt !== exp_seq[i]) begin errors++; $display("FAIL contention_gnt[%0d] got %b exp %b", i, gnt, exp_seq[i]); end
         checks++; if (rvalid !== prev) begin errors++; $display("FAIL contention_rvalid[%0d] got %b exp %b", i, rvalid, prev); end
         prev = exp_seq[i];
         @(negedge clk);
      end
      req = '0;
      #1;
      checks++; if (rvalid !== prev) begin errors++; $display("FAIL contention_rvalid_last got %b exp %b", rvalid, prev); end
   endtask

   task automatic test_wrap();
      do_reset();
      req = 3'b010;
      #1;
      checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL wrap_setup got %b exp 010", gnt); end
      @(negedge clk);
      req = 3'b101;
      #1;
      checks++; if (dut.rr_q !== 2'd2) begin errors++; $display("FAIL wrap_rr_start got %0d exp 2", dut.rr_q); end
      checks++; if (gnt !== 3'b100) begin errors++; $display("FAIL wrap_first got %b exp 100", gnt); end
      @(negedge clk);
      #1;
      checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL wrap_second got %b exp 001", gnt); end
      @(negedge clk);
      req = '0;
      #1;
      checks++; if (dut.rr_q !== 2'd1) begin errors++; $display("FAIL wrap_rr_end got %0d exp 1", dut.rr_q); end
      checks++; if (rvalid !== 3'b001) begin errors++; $display("FAIL wrap_rvalid got %b exp 001", rvalid); end
   endtask

   task automatic test_inactive();
      do_reset();
      dmactive = 1'b0;
      set_port(0, 1'b0, 32'h8, 4'hF, 32'h0);
      set_port(1, 1'b0, 32'hC, 4'hF, 32'h0);
      req = 3'b011;
      #1;
      checks++; if (gnt !== 3'b000 || mem_req !== 1'b0)
         begin errors++; $display("FAIL inactive_block got gnt=%b req=%b exp 000 0", gnt, mem_req); end
      checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL inactive_addr got %h exp 0", mem_addr); end
      @(negedge clk);
      dmactive = 1'b1;
      req = 3'b001;
      #1;
      checks++; if (gnt !== 3'b001) begin errors++; $display("FAIL inactive_grant got %b exp 001", gnt); end
      @(negedge clk);
      dmactive = 1'b0;
      req = 3'b010;
      #1;
      checks++; if (gnt !== 3'b000) begin errors++; $display("FAIL inactive_drop_gnt got %b exp 000", gnt); end
      checks++; if (rvalid !== 3'b001) begin errors++; $display("FAIL inactive_pending got %b exp 001", rvalid); end
      @(negedge clk);
      #1;
      checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL inactive_after got %b exp 000", rvalid); end
      dmactive = 1'b1;
      req = '0;
   endtask

   task automatic test_write_reset();
      do_reset();
      set_port(1, 1'b1, 32'h40, 4'b0011, 32'h5A5A5A5A);
      req = 3'b010;
      #1;
      checks++; if (gnt !== 3'b010) begin errors++; $display("FAIL wr_gnt got %b exp 010", gnt); end
      checks++; if (mem_we !== 1'b1 || mem_be !== 4'b0011 || mem_wdata !== 32'h5A5A5A5A || mem_addr !== 32'h40)
         begin errors++; $display("FAIL wr_mem got we=%b be=%b d=%h a=%h exp 1 0011 5a5a5a5a 40", mem_we, mem_be, mem_wdata, mem_addr); end
      ref_write(32'h40, 4'b0011, 32'h5A5A5A5A);
      @(negedge clk);
      req = '0;
      #1;
      checks++; if (rvalid !== 3'b010) begin errors++; $display("FAIL wr_ack got %b exp 010", rvalid); end
      rst = 1'b1;
      #1;
      checks++; if (rvalid !== 3'b000) begin errors++; $display("FAIL wr_rst_rvalid got %b exp 000", rvalid); end
      checks++; if (dut.rr_q !== 2'd0) begin errors++; $display("FAIL wr_rst_rr got %0d exp 0", dut.rr_q); end
      @(negedge clk);
      rst = 1'b0;
      m_ptr = 0;
   endtask

   task automatic test_random();
      logic [N-1:0] exp_gnt, prev_gnt;
      logic prev_read;
      int gp;
      logic [DW-1:0] exp_d;
      do_reset();
      prev_gnt = '0;
      prev_read = 1'b0;
      for (int it = 0; it < 400; it++) begin
         dmactive = ($urandom_range(0, 7) != 0);
         req = N'($urandom_range(0, (1 << N) - 1));
         for (int p = 0; p < N; p++)
            set_port(p, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)) << 2,
                     4'($urandom_range(0, 15)), $urandom);
         #1;
         exp_gnt = model_grant(req, dmactive, m_ptr, gp);
         checks++; if (gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt[%0d] got %b exp %b", it, gnt, exp_gnt); end
         checks++; if (mem_req !== (gp >= 0)) begin errors++; $display("FAIL rnd_mem_req[%0d] got %b exp %b", it, mem_req, gp >= 0); end
         if (gp >= 0) begin
            checks++;
            if (mem_we !== p_we[gp] || mem_addr !== p_addr[gp] || mem_be !== p_be[gp] || mem_wdata !== p_wdata[gp])
               begin errors++; $display("FAIL rnd_mux[%0d] got we=%b a=%h be=%b d=%h exp port %0d", it, mem_we, mem_addr, mem_be, mem_wdata, gp); end
         end
         checks++; if (rvalid !== prev_gnt) begin errors++; $display("FAIL rnd_rvalid[%0d] got %b exp %b", it, rvalid, prev_gnt); end
         if (prev_read) begin
            exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
            checks++; if (rdata !== exp_d) begin errors++; $display("FAIL rnd_rdata[%0d] got %h exp %h", it, rdata, exp_d); end
         end
         if (gp >= 0) begin
            if (p_we[gp]) ref_write(p_addr[gp], p_be[gp], p_wdata[gp]);
            else exp_q.push_back(ref_mem[p_addr[gp][9:2]]);
            m_ptr = (gp + 1) % N;
         end
         prev_gnt = exp_gnt;
         prev_read = (gp >= 0) && !p_we[gp];
         @(negedge clk);
      end
      set_idle();
   endtask

`ifdef DM_MEM_ARB_STATS_EN
   task automatic test_stats();
      do_reset();
      req = 3'b001;
      for (int i = 0; i < 10; i++) @(negedge clk);
      checks++; if (grant_cnt[15:0] !== 16'd10) begin errors++; $display("FAIL stats_count got %0d exp 10", grant_cnt[15:0]); end
      for (int i = 0; i < 69990; i++) @(negedge clk);
      checks++; if (grant_cnt[15:0] !== 16'hFFFF) begin errors++; $display("FAIL stats_sat got %h exp ffff", grant_cnt[15:0]); end
      checks++; if (grant_cnt[31:16] !== 16'd0) begin errors++; $display("FAIL stats_port1 got %h exp 0", grant_cnt[31:16]); end
      dmactive = 1'b0;
      @(negedge clk);
      checks++; if (grant_cnt[15:0] !== 16'd0) begin errors++; $display("FAIL stats_clear got %h exp 0", grant_cnt[15:0]); end
      dmactive = 1'b1;
      req = '0;
   endtask
`endif

   initial begin
      rst = 1'b1;
      dmactive = 1'b0;
      set_idle();
      for (int i = 0; i < 256; i++) begin
         slave_mem[i] = $urandom;
         ref_mem[i]   = slave_mem[i];
      end
      #2;
      test_reset();
      test_single_read();
      test_contention();
      test_wrap();
      test_inactive();
      test_write_reset();
      test_random();
`ifdef DM_MEM_ARB_STATS_EN
      test_stats();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
